// File: rtl/song_judge.sv
// -----------------------------------------------------------------------------
// song_judge
//
// Rhythm-game judging stage. A start pulse launches playback of one stored
// song: for every step the expected note is fetched from an external
// synchronous ROM, shown on guide_key, and the player's first new key press
// inside the step window is judged as a hit or a miss. Hit and miss totals
// saturate at 255 and are held after the song ends or is aborted so the
// score screen can show them.
//
// Parameters
//   STEP_CYCLES  PLAY cycles per note step (2..65535)
//   SONG_LEN     notes per song (1..16)
//
// Ports
//   CLK         system clock, rising edge
//   RESETN      asynchronous reset, active high
//   start       begin a song (honoured in IDLE and DONE only)
//   abort       return to IDLE from any state, beats start
//   song_sel    song number, latched at start
//   key         player keys, synchronous to CLK, bit n = note n
//   rom_addr    note ROM address {latched song, step}
//   rom_data    one-hot expected note from ROM (0 = rest), 1-cycle latency
//   guide_key   expected note of the current step
//   hit_pulse   one-cycle pulse per hit
//   miss_pulse  one-cycle pulse per miss
//   hit_cnt     saturating hit total
//   miss_cnt    saturating miss total
//   led_code    00 neutral, 01 hit, 10 miss, 11 song done
//   busy        high in FETCH, LOAD and PLAY
//   done        high in DONE
// -----------------------------------------------------------------------------
module song_judge #(
    parameter int STEP_CYCLES = 8,
    parameter int SONG_LEN    = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] song_sel,
    input  logic [7:0] key,
    output logic [6:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] guide_key,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] hit_cnt,
    output logic [7:0] miss_cnt,
    output logic [1:0] led_code,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_PLAY  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [15:0] LAST_CYC  = 16'(STEP_CYCLES - 1);
    localparam logic [3:0]  LAST_STEP = 4'(SONG_LEN - 1);

    localparam logic [1:0] LED_NEUTRAL = 2'b00;
    localparam logic [1:0] LED_HIT     = 2'b01;
    localparam logic [1:0] LED_MISS    = 2'b10;
    localparam logic [1:0] LED_DONE    = 2'b11;

    logic [2:0]  state;
    logic [3:0]  step;
    logic [15:0] cyc_cnt;
    logic [7:0]  key_q;
    logic [2:0]  sel_q;
    logic        pressed;

    logic [7:0]  press;
    logic        in_play;
    logic        last_cyc;
    logic        first_press;
    logic        is_hit;
    logic        is_miss;

    // Only rising key edges count, so a key held across a step boundary
    // cannot be judged twice.
    assign press       = key & ~key_q;
    assign in_play     = (state == ST_PLAY);
    assign last_cyc    = (cyc_cnt == LAST_CYC);
    assign first_press = in_play && !pressed && (press != 8'd0);
    assign is_hit      = first_press && (press == guide_key) && (guide_key != 8'd0);
    // A press in the final cycle counts as the step's press, so the
    // end-of-step miss is only taken when no press was seen at all.
    assign is_miss     = (first_press && !is_hit) ||
                         (in_play && !pressed && (press == 8'd0) && last_cyc &&
                          (guide_key != 8'd0));

    assign rom_addr = {sel_q, step};
    assign busy     = (state == ST_FETCH) || (state == ST_LOAD) || (state == ST_PLAY);
    assign done     = (state == ST_DONE);

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples the pre-edge values of the others; blocking writes here
    // would make the result depend on statement order.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state      <= ST_IDLE;
            step       <= 4'd0;
            cyc_cnt    <= 16'd0;
            key_q      <= 8'd0;
            sel_q      <= 3'd0;
            pressed    <= 1'b0;
            guide_key  <= 8'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            hit_cnt    <= 8'd0;
            miss_cnt   <= 8'd0;
            led_code   <= LED_NEUTRAL;
        end else begin
            key_q      <= key;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;

            if (abort) begin
                // Counts are deliberately left alone for the score screen.
                state     <= ST_IDLE;
                guide_key <= 8'd0;
                led_code  <= LED_NEUTRAL;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            sel_q    <= song_sel;
                            step     <= 4'd0;
                            hit_cnt  <= 8'd0;
                            miss_cnt <= 8'd0;
                            state    <= ST_FETCH;
                        end
                    end

                    // rom_addr is presented this cycle; data arrives next cycle.
                    ST_FETCH: state <= ST_LOAD;

                    ST_LOAD: begin
                        guide_key <= rom_data;
                        led_code  <= LED_NEUTRAL;
                        cyc_cnt   <= 16'd0;
                        pressed   <= 1'b0;
                        state     <= ST_PLAY;
                    end

                    ST_PLAY: begin
                        if (is_hit) begin
                            hit_pulse <= 1'b1;
                            led_code  <= LED_HIT;
                            if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
                        end
                        if (is_miss) begin
                            miss_pulse <= 1'b1;
                            led_code   <= LED_MISS;
                            if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
                        end
                        if (first_press) pressed <= 1'b1;

                        if (last_cyc) begin
                            if (step == LAST_STEP) begin
                                // Song end overrides the judgement colour of
                                // the final cycle; the pulse still fires.
                                state     <= ST_DONE;
                                guide_key <= 8'd0;
                                led_code  <= LED_DONE;
                            end else begin
                                step  <= step + 4'd1;
                                state <= ST_FETCH;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + 16'd1;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
